// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: streams RGB332 pixels for one frame from a byte-wide
// framebuffer read port into a prefetch FIFO and hands one pixel per
// pix_rdy to the VGA sync stage.
// Optional feature: define VGA_FETCH_UFL_CNT_EN to add the saturating
// ufl_count port that counts underflow pops since reset.
module vga_pixel_fetch #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int FIFO_DEPTH = 16,
   localparam int NPIX      = H_ACTIVE * V_ACTIVE,
   localparam int AW        = $clog2(NPIX)
) (
   input  logic          app_clk,
   input  logic          app_arst,
   input  logic          frame_start,
   input  logic          pix_rdy,
   output logic [7:0]    pix_data,
   output logic          pix_valid,
   output logic          underflow,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [7:0]    mem_rdata
`ifdef VGA_FETCH_UFL_CNT_EN
   ,
   output logic [15:0]   ufl_count
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, FETCH, DONE, FLUSH} state_t;

   state_t          state_q, state_d;
   logic            mem_req_q, mem_req_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   // reads granted but not yet returned; in FLUSH these are the stale ones
   logic [CW-1:0]   outs_q, outs_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [7:0]      pix_data_q, pix_data_d;
   logic            pix_valid_q, pix_valid_d;
   logic            underflow_q, underflow_d;
`ifdef VGA_FETCH_UFL_CNT_EN
   logic [15:0]     ufl_count_q, ufl_count_d;
`endif
   logic [7:0]      fifo_mem [FIFO_DEPTH];

   logic            gnt;
   logic            rsp;
   logic            push;
   logic            pop;

   assign gnt = mem_req_q & mem_gnt;
   // a response only counts against a read we actually have in flight,
   // so stray rvalids (e.g. after reset) are ignored
   assign rsp = mem_rvalid & (outs_q != '0);

   // next-state: restart, address/credit tracking, FIFO push/pop, pixel out
   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      cnt_d       = cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      pix_data_d  = pix_data_q;
      pix_valid_d = pix_valid_q;
      underflow_d = underflow_q;
`ifdef VGA_FETCH_UFL_CNT_EN
      ufl_count_d = ufl_count_q;
`endif
      push        = 1'b0;
      pop         = 1'b0;
      outs_d      = outs_q + CW'(gnt) - CW'(rsp);

      if (frame_start) begin
         // restart wins over everything; coincident grant/response is
         // already folded into outs_d and becomes part of the discard count
         cnt_d       = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         mem_addr_d  = '0;
         underflow_d = 1'b0;
         state_d     = (outs_d == '0) ? FETCH : FLUSH;
      end else begin
         case (state_q)
            FETCH: begin
               push = rsp;
               if (gnt) begin
                  mem_addr_d = mem_addr_q + AW'(1);
                  if (mem_addr_q == AW'(NPIX - 1))
                     state_d = DONE;
               end
            end
            DONE:    push = rsp;
            FLUSH:   if (outs_d == '0) state_d = FETCH;
            default: ;
         endcase

         if (pix_rdy) begin
            if (cnt_q != '0) begin
               pop         = 1'b1;
               pix_data_d  = fifo_mem[rd_ptr_q];
               pix_valid_d = 1'b1;
            end else begin
               pix_data_d  = 8'h00;
               pix_valid_d = 1'b0;
               underflow_d = 1'b1;
`ifdef VGA_FETCH_UFL_CNT_EN
               if (ufl_count_q != 16'hFFFF)
                  ufl_count_d = ufl_count_q + 16'd1;
`endif
            end
         end

         cnt_d    = cnt_q + CW'(push) - CW'(pop);
         wr_ptr_d = wr_ptr_q + PW'(push);
         rd_ptr_d = rd_ptr_q + PW'(pop);
      end

      // credit rule: never have more reads in flight than free FIFO slots
      mem_req_d = (state_d == FETCH) &&
                  (({1'b0, cnt_d} + {1'b0, outs_d}) < (CW + 1)'(FIFO_DEPTH));
   end

   // state and registered outputs
   always_ff @(posedge app_clk or posedge app_arst) begin
      if (app_arst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         outs_q      <= '0;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         pix_data_q  <= 8'h00;
         pix_valid_q <= 1'b0;
         underflow_q <= 1'b0;
`ifdef VGA_FETCH_UFL_CNT_EN
         ufl_count_q <= 16'h0000;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         outs_q      <= outs_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         pix_data_q  <= pix_data_d;
         pix_valid_q <= pix_valid_d;
         underflow_q <= underflow_d;
`ifdef VGA_FETCH_UFL_CNT_EN
         ufl_count_q <= ufl_count_d;
`endif
      end
   end

   // FIFO storage; occupancy lives in cnt_q so the array needs no reset
   always_ff @(posedge app_clk) begin
      if (push)
         fifo_mem[wr_ptr_q] <= mem_rdata;
   end

   assign pix_data  = pix_data_q;
   assign pix_valid = pix_valid_q;
   assign underflow = underflow_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
`ifdef VGA_FETCH_UFL_CNT_EN
   assign ufl_count = ufl_count_q;
`endif

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch on a reduced 40x3 frame so a whole
// frame fits in a short run. Memory model: grant gated by gnt_en, response
// after 'lat' clock edges, rdata = addr[7:0] + salt.
module tb_vga_pixel_fetch;
   localparam int H  = 40;
   localparam int V  = 3;
   localparam int N  = H * V;
   localparam int AW = $clog2(N);

   typedef struct packed {logic v; logic [7:0] d;} px_t;

   logic          app_clk = 1'b0;
   logic          app_arst = 1'b1;
   logic          frame_start = 1'b0;
   logic          pix_rdy = 1'b0;
   logic [7:0]    pix_data;
   logic          pix_valid;
   logic          underflow;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_gnt;
   logic          mem_rvalid = 1'b0;
   logic [7:0]    mem_rdata = 8'h00;
   logic [15:0]   ufl_count;

   logic          gnt_en = 1'b1;
   int            lat = 2;
   logic [7:0]    salt = 8'h00;
   int            gcnt = 0;
   px_t           dl [0:15] = '{default: '0};

   int            checks = 0;
   int            failures = 0;
   px_t           expq [$];

   vga_pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(16)) dut (
      .app_clk    (app_clk),
      .app_arst   (app_arst),
      .frame_start(frame_start),
      .pix_rdy    (pix_rdy),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .underflow  (underflow),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
`ifdef VGA_FETCH_UFL_CNT_EN
      ,
      .ufl_count  (ufl_count)
`endif
   );

`ifndef VGA_FETCH_UFL_CNT_EN
   assign ufl_count = 16'h0000;
`endif

   always #5 app_clk = ~app_clk;

   assign mem_gnt = mem_req & gnt_en;

   // memory: a grant seen at negedge lands at the next posedge; its data
   // is presented so the DUT samples rvalid 'lat' edges later
   always @(negedge app_clk) begin
      for (int i = 15; i > 0; i--) dl[i] = dl[i-1];
      dl[0].v = mem_req && mem_gnt && !app_arst;
      dl[0].d = 8'(mem_addr) + salt;
      if (dl[0].v) gcnt = gcnt + 1;
      mem_rvalid = dl[lat].v;
      mem_rdata  = dl[lat].d;
   end

   task automatic tick();
      @(posedge app_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // compares every pop against the next expected pixel
   task automatic monitor();
      px_t e;
      forever begin
         @(posedge app_clk);
         if (!app_arst && pix_rdy) begin
            #1;
            checks++;
            if (expq.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected_pop actual=%0h expected=none", {pix_valid, pix_data});
            end else begin
               e = expq.pop_front();
               if ({pix_valid, pix_data} !== e) begin
                  failures++;
                  $display("FAIL sb_pixel actual=v%0b/%0h expected=v%0b/%0h",
                           pix_valid, pix_data, e.v, e.d);
               end
            end
         end
      end
   endtask

   task automatic pop_px(input int n, input int base, input logic v);
      px_t e;
      for (int i = 0; i < n; i++) begin
         e.v = v;
         e.d = v ? 8'(base + i) : 8'h00;
         expq.push_back(e);
         pix_rdy = 1'b1;
         tick();
      end
      pix_rdy = 1'b0;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   initial begin
      int base;
      fork
         monitor();
      join_none

      // reset state
      repeat (3) tick();
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_pix_data", 32'(pix_data), 0);
      chk("rst_pix_valid", 32'(pix_valid), 0);
      chk("rst_underflow", 32'(underflow), 0);
      app_arst = 1'b0;
      repeat (2) tick();
      chk("idle_no_req", 32'(mem_req), 0);

      // full frame: prefetch stalls at 16 credits, then stream all pixels
      pulse_fs();
      base = gcnt;
      chk("fs_req_next_cycle", 32'(mem_req), 1);
      chk("fs_addr_zero", 32'(mem_addr), 0);
      repeat (30) tick();
      chk("prefetch_grants", 32'(gcnt - base), 16);
      chk("prefetch_addr", 32'(mem_addr), 16);
      chk("prefetch_stall", 32'(mem_req), 0);
      pop_px(N, 0, 1'b1);
      repeat (10) tick();
      chk("done_no_req", 32'(mem_req), 0);
      chk("frame_no_underflow", 32'(underflow), 0);

      // memory stall: empty pops give black, set sticky underflow
      gnt_en = 1'b0;
      pulse_fs();
      pop_px(8, 0, 1'b0);
      chk("stall_underflow", 32'(underflow), 1);
`ifdef VGA_FETCH_UFL_CNT_EN
      chk("ufl_count_8", 32'(ufl_count), 8);
`endif
      repeat (32) tick();
      chk("stall_req_held", 32'(mem_req), 1);
      chk("stall_addr_held", 32'(mem_addr), 0);
      gnt_en = 1'b1;
      repeat (20) tick();
      pop_px(4, 0, 1'b1);
      chk("underflow_sticky", 32'(underflow), 1);

      // restart with 5 reads outstanding: stale data (salted) must vanish
      gnt_en = 1'b0;
      repeat (10) tick();
      lat  = 8;
      salt = 8'h80;
      pulse_fs();
      base = gcnt;
      gnt_en = 1'b1;
      repeat (5) tick();
      gnt_en = 1'b0;
      chk("flush_setup_grants", 32'(gcnt - base), 5);
      salt = 8'h00;
      pulse_fs();
      gnt_en = 1'b1;
      chk("flush_req_low", 32'(mem_req), 0);
      chk("flush_addr_zero", 32'(mem_addr), 0);
      chk("flush_underflow_clr", 32'(underflow), 0);
      repeat (40) tick();
      pop_px(4, 0, 1'b1);

      // asynchronous reset mid-fetch, late responses land in IDLE
      gnt_en = 1'b0;
      repeat (12) tick();
      lat = 4;
      pulse_fs();
      gnt_en = 1'b1;
      repeat (3) tick();
      #3;
      app_arst = 1'b1;
      #1;
      chk("arst_mem_req", 32'(mem_req), 0);
      chk("arst_mem_addr", 32'(mem_addr), 0);
      chk("arst_pix_valid", 32'(pix_valid), 0);
      chk("arst_pix_data", 32'(pix_data), 0);
      chk("arst_underflow", 32'(underflow), 0);
`ifdef VGA_FETCH_UFL_CNT_EN
      chk("arst_ufl_count", 32'(ufl_count), 0);
`endif
      tick();
      app_arst = 1'b0;
      repeat (8) tick();
      chk("idle_after_arst_req", 32'(mem_req), 0);
      pop_px(1, 0, 1'b0);
`ifdef VGA_FETCH_UFL_CNT_EN
      chk("ufl_count_after_arst", 32'(ufl_count), 1);
`endif

      repeat (3) tick();
      chk("sb_drained", 32'(expq.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Upstream pixel source for the VGA sync/timing stage. Streams RGB332 pixels for one 640x480 frame from a byte-wide framebuffer read port into a small prefetch FIFO. Pops one pixel per cycle whenever the sync stage requests one during active video. Restarts cleanly on every frame-start pulse, including when reads are still in flight.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- FIFO_DEPTH, 16, prefetch entries (power of two, at least 4)

Ports:
- app_clk  in  1  sole clock, 25 MHz pixel clock
- app_arst  in  1  reset, asynchronous, active-high
- frame_start  in  1  one-cycle pulse from the sync stage at the start of each frame (during vertical blanking)
- pix_rdy  in  1  sync stage consumes one pixel this cycle (active video only)
- pix_data  out  8  RGB332 pixel {r[2:0],g[2:0],b[1:0]}
- pix_valid  out  1  pix_data holds a real framebuffer pixel (0 = underflow black)
- underflow  out  1  sticky flag: a pix_rdy found the FIFO empty this frame
- mem_req  out  1  read request
- mem_addr  out  19  byte address, row*H_ACTIVE+col, width $clog2(H_ACTIVE*V_ACTIVE)
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; responses return in order, at least 1 cycle after gnt
- mem_rdata  in  8  read data
- ufl_count  out  16  saturating underflow count (only when VGA_FETCH_UFL_CNT_EN is defined)

## Operation
- Reset: state IDLE, mem_req=0, mem_addr=0, pix_data=8'h00, pix_valid=0, underflow=0, FIFO empty, outstanding=0, ufl_count=0.
- States:
  - IDLE: no requests; waits for frame_start.
  - FETCH: issues requests.
  - DONE: all H_ACTIVE*V_ACTIVE addresses issued.
  - FLUSH: discards stale in-flight responses.
- frame_start, in any state:
  - FIFO is emptied, mem_addr is set to 0, underflow is cleared.
  - If outstanding==0, go to FETCH; otherwise go to FLUSH with discard=outstanding.
- FLUSH:
  - Each mem_rvalid decrements discard; its data is dropped.
  - A pending mem_req is withdrawn (a grant in that same cycle counts as outstanding).
  - When discard reaches 0, go to FETCH.
- FETCH:
  - mem_req=1 while fifo_count+outstanding < FIFO_DEPTH.
  - On mem_gnt: mem_addr increments and outstanding increments.
  - After the grant of address H_ACTIVE*V_ACTIVE-1, go to DONE.
- Response handling: mem_rvalid outside FLUSH pushes mem_rdata and decrements outstanding. The credit rule guarantees the FIFO never overflows.
- Pop, on pix_rdy:
  - FIFO non-empty: pix_data is set to the head, pix_valid=1.
  - FIFO empty: pix_data=8'h00, pix_valid=0, underflow=1.
  - pix_rdy=0: pix_data and pix_valid hold.
- Simultaneous push and pop on the same cycle: both take effect; the count is unchanged.
- A frame_start on the same cycle as a pop, grant or rvalid takes priority. The FIFO ends empty, and a coincident grant or rvalid is accounted into discard.

## Timing
- pix_data/pix_valid are registered: pix_rdy at edge N gives output valid after edge N.
- Minimum prefetch latency from frame_start (no outstanding reads): mem_req high in cycle +1. The first pixel is available 2 cycles after the first rvalid.
- mem_req/mem_addr hold stable while mem_req=1 and mem_gnt=0, except on frame_start or entry to FLUSH.
- Sustained throughput is one pixel per cycle if the memory grants every cycle and round-trip latency is below FIFO_DEPTH.
- Reset deasserts asynchronously to IDLE; mid-frame reset drops all state. Any response arriving while in IDLE after reset is ignored.

## Configuration
- VGA_FETCH_UFL_CNT_EN defined:
  - ufl_count port exists and increments on every underflow pop, saturating at 16'hFFFF.
  - Cleared only by app_arst, not by frame_start.
- Undefined: no ufl_count port or counter; only the sticky underflow flag exists.

## Test plan
- Reset, then frame_start, memory with 1-cycle grant and 2-cycle rvalid and rdata=addr[7:0] -> mem_addr counts 0..15 then stalls until pops. After 640 pix_rdy pulses per line, pix_data sequence is 0x00,0x01,...; underflow stays 0 over a full frame.
- Memory stalls (mem_gnt=0 for 40 cycles) while pix_rdy=1 -> pix_valid=0, pix_data=0x00, underflow=1. ufl_count equals the number of empty pops when the macro is defined.
- frame_start with 5 reads outstanding -> FLUSH drops exactly 5 responses; the next pixel delivered is the byte at address 0.
- Run to DONE (address 307199 granted) -> mem_req stays 0 until the next frame_start; the FIFO drains the last pixels correctly.
- Assert app_arst mid-FETCH -> all outputs return to reset values immediately; a late rvalid in IDLE leaves the FIFO empty.
- Back-pressure check: hold pix_rdy=0 with instant memory -> fifo_count+outstanding never exceeds 16.
